// File: rtl/axi_rd_req_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared between the request arbiter and the memory side.
interface axi_rd_req_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_req_arbiter.sv
// Round-robin AR arbiter for decompressor read requesters; R beats are routed back in
// order using the one-hot owner recorded in an external id FIFO at each AR handshake.
module axi_rd_req_arbiter #(
  parameter int NUM_DECOMPRESSOR = 2,
  parameter int ADDR_W           = 64,
  parameter int DATA_W           = 512
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_DECOMPRESSOR-1:0]        req_valid,
  input  logic [NUM_DECOMPRESSOR*ADDR_W-1:0] req_addr,
  input  logic [NUM_DECOMPRESSOR*8-1:0]      req_len,
  output logic [NUM_DECOMPRESSOR-1:0]        req_ready,
  axi_rd_req_arbiter_if.master               m_axi,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic                               rsp_last,
  output logic [NUM_DECOMPRESSOR-1:0]        rsp_valid,
  input  logic [NUM_DECOMPRESSOR-1:0]        rsp_ready,
  output logic                               fifo_wr_en,
  output logic [NUM_DECOMPRESSOR-1:0]        fifo_select_in,
  input  logic                               fifo_full,
  output logic                               fifo_rd_en,
  input  logic [NUM_DECOMPRESSOR-1:0]        fifo_select_out,
  input  logic                               fifo_empty,
  output logic [3:0]                         outstanding,
  output logic                               err
);

  localparam int RR_W = (NUM_DECOMPRESSOR > 1) ? $clog2(NUM_DECOMPRESSOR) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [RR_W-1:0]               last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [NUM_DECOMPRESSOR-1:0]   sel_q, sel_d;
  logic [3:0]                    outstanding_q, outstanding_d;
  logic                          err_q, err_d;

  logic                          found;
  logic [RR_W-1:0]               win_idx;
  logic [NUM_DECOMPRESSOR-1:0]   win_oh;
  logic                          ar_push;
  logic                          r_pop;
  logic                          underflow;

  // Round-robin scan starting one past the previous winner, wrapping modulo the requester count.
  always_comb begin
    found   = 1'b0;
    win_idx = {RR_W{1'b0}};
    win_oh  = {NUM_DECOMPRESSOR{1'b0}};
    for (int k = 1; k <= NUM_DECOMPRESSOR; k++) begin
      int cand;
      cand = (int'(last_grant_q) + k) % NUM_DECOMPRESSOR;
      if (!found && req_valid[cand]) begin
        found        = 1'b1;
        win_idx      = cand[RR_W-1:0];
        win_oh[cand] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // AR FSM: grant in IDLE, hold the latched request in ISSUE until the handshake.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    sel_d        = sel_q;
    req_ready    = {NUM_DECOMPRESSOR{1'b0}};
    ar_push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && found && !fifo_full) begin
          req_ready    = win_oh;
          last_grant_d = win_idx;
          addr_d       = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          len_d        = req_len[int'(win_idx)*8 +: 8];
          sel_d        = win_oh;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (m_axi.arready) begin
          ar_push = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m_axi.arvalid  = (state_q == ISSUE);
  assign m_axi.araddr   = addr_q;
  assign m_axi.arlen    = len_q;
  assign fifo_wr_en     = ar_push;
  assign fifo_select_in = sel_q;

  // Responses follow the id FIFO head strictly; a stalled owner blocks everyone behind it.
  assign rsp_data     = m_axi.rdata;
  assign rsp_last     = m_axi.rlast;
  assign rsp_valid    = {NUM_DECOMPRESSOR{m_axi.rvalid & ~fifo_empty}} & fifo_select_out;
  assign m_axi.rready = ~fifo_empty & (|(fifo_select_out & rsp_ready));
  assign r_pop        = m_axi.rvalid & m_axi.rready & m_axi.rlast;
  assign fifo_rd_en   = r_pop;

  // Outstanding-burst bookkeeping and sticky protocol error detection.
  always_comb begin
    outstanding_d = outstanding_q;
    underflow     = 1'b0;
    if (ar_push && !r_pop) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (r_pop && !ar_push) begin
      if (outstanding_q == 4'd0) begin
        underflow = 1'b1;
      end else begin
        outstanding_d = outstanding_q - 4'd1;
      end
    end else begin
      outstanding_d = outstanding_q;
    end
    err_d = err_q | (m_axi.rvalid & fifo_empty) | underflow;
  end

  assign outstanding = outstanding_q;
  assign err         = err_q;

  // State registers with synchronous reset; requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= RR_W'(NUM_DECOMPRESSOR - 1);
      addr_q        <= {ADDR_W{1'b0}};
      len_q         <= 8'd0;
      sel_q         <= {NUM_DECOMPRESSOR{1'b0}};
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      sel_q         <= sel_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: doc/axi_rd_req_arbiter.md
Name: axi_rd_req_arbiter

Overview:
- Shares one AXI4 read master port among NUM_DECOMPRESSOR decompressor read requesters.
- Arbitrates AR requests round-robin and issues them on the AR channel.
- Pushes the one-hot grant of each accepted AR into the external axi_id_fifo write side.
- Pops that FIFO on each R burst's final beat, routing R beats back to the requester that owns the oldest outstanding burst.

Parameters:
- NUM_DECOMPRESSOR, 2, number of requesters; must match the axi_id_fifo instance.
- ADDR_W, 64, AXI address width.
- DATA_W, 512, AXI read data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high. The top level drives the id FIFO's rst_n from ~rst.
- req_valid  in  NUM_DECOMPRESSOR  per-requester read request valid.
- req_addr  in  NUM_DECOMPRESSOR*ADDR_W  per-requester byte address; slice i belongs to requester i.
- req_len  in  NUM_DECOMPRESSOR*8  per-requester AXI burst length minus 1.
- req_ready  out  NUM_DECOMPRESSOR  one-cycle one-hot grant pulse.
- m_axi_araddr  out  ADDR_W  AR address.
- m_axi_arlen  out  8  AR burst length.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rdata  in  DATA_W  R data.
- m_axi_rlast  in  1  R last beat.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- rsp_data  out  DATA_W  R data broadcast to all requesters.
- rsp_last  out  1  rlast broadcast.
- rsp_valid  out  NUM_DECOMPRESSOR  per-requester beat valid.
- rsp_ready  in  NUM_DECOMPRESSOR  per-requester beat ready.
- fifo_wr_en  out  1  id FIFO push.
- fifo_select_in  out  NUM_DECOMPRESSOR  one-hot grant to push.
- fifo_full  in  1  id FIFO full.
- fifo_rd_en  out  1  id FIFO pop.
- fifo_select_out  in  NUM_DECOMPRESSOR  head entry of the id FIFO (combinational).
- fifo_empty  in  1  id FIFO empty.
- outstanding  out  4  count of accepted ARs whose last R beat has not yet been accepted.
- err  out  1  sticky protocol error flag.

Behaviour:

Reset values:
- All registered outputs clear to 0: req_ready, m_axi_arvalid, fifo_wr_en, outstanding, err.
- FSM resets to IDLE.
- Round-robin pointer last_grant resets to NUM_DECOMPRESSOR-1, so requester 0 has first priority.

Reset mid-operation:
- A latched AR is abandoned and arvalid drops in the next cycle.
- The id FIFO is cleared by the same reset.

AR FSM, two states:
- IDLE:
  - If |req_valid and !fifo_full, grant the first set req_valid bit scanning upward from last_grant+1 with wrap.
  - The grant cycle is T. Latch req_addr/req_len of the winner, pulse req_ready[winner] for cycle T only, update last_grant, and go to ISSUE.
  - If fifo_full, do not grant; remain in IDLE.
- ISSUE:
  - m_axi_arvalid=1 from T+1; araddr/arlen held stable until the handshake.
  - On the cycle arvalid&&arready, drive fifo_wr_en=1 combinationally with fifo_select_in = latched one-hot, increment outstanding, and return to IDLE.
  - The next grant can occur no earlier than the cycle after the handshake. Peak rate is therefore 1 AR per 2 cycles.
- Each grant pushes exactly one FIFO entry. The grant is checked against fifo_full, so at most 7 ARs are outstanding (FIFO capacity).

R routing (combinational, zero latency):
- rsp_data = m_axi_rdata; rsp_last = m_axi_rlast.
- rsp_valid[i] = m_axi_rvalid & !fifo_empty & fifo_select_out[i].
- m_axi_rready = !fifo_empty & |(fifo_select_out & rsp_ready).
- fifo_rd_en = m_axi_rvalid & m_axi_rready & m_axi_rlast.
- outstanding decrements on the same cycle as fifo_rd_en.
- If an AR handshake and a final-beat pop occur in the same cycle, outstanding is unchanged.

Backpressure:
- If the owning requester's rsp_ready=0, rready=0. The beat stalls and no other requester is served; responses stay strictly in order.

Error:
- err set when m_axi_rvalid=1 while fifo_empty=1 (unsolicited beat); rready stays 0 in that case.
- err also set if outstanding would underflow.
- err cleared only by rst.

Width rules:
- outstanding is 4-bit, saturating at 7 by construction.
- Round-robin index is $clog2(NUM_DECOMPRESSOR) bits, wrapping modulo NUM_DECOMPRESSOR.

Test Plan:
- Single request: req_valid=01, addr 0x1000, len 3, arready=1 one cycle after arvalid -> req_ready=01 at T, arvalid at T+1, fifo_wr_en with select 01, outstanding=1. Then 4 R beats with rlast on the 4th -> rsp_valid=01 on each, fifo_rd_en once, outstanding=0.
- Fairness: req_valid=11 held continuously -> grants alternate 01,10,01,10 starting with 01 after reset.
- Full: fifo_full=1 with req_valid=01 for 10 cycles -> no req_ready, no arvalid. Drop fifo_full -> grant on the next cycle.
- Out-of-order readiness: FIFO holds [10,01] and rsp_ready=01 only -> rready=0, beats stall. Raise rsp_ready[1] -> burst goes to requester 1 first.
- Simultaneous events: AR handshake in the same cycle as a last-beat pop -> outstanding unchanged, FIFO pushes and pops both occur.
- Error and reset: rvalid=1 with fifo_empty=1 -> err=1, rready=0. Assert rst during ISSUE -> arvalid=0 and err=0 the next cycle.
